// File: rtl/moore_seq_n.sv
// moore_seq_n: up/down step counter with Moore outputs.
// Q (binary or Gray), TC and Wrap are derived only from registered state.
// Priority each cycle: Reset > Load > I > hold.
module moore_seq_n #(
  parameter int WIDTH    = 2,
  parameter int GRAY     = 0,
  parameter int SATURATE = 0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             I,
  input  logic             S,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Dir,
  output logic             TC,
  output logic             Wrap
);

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic             at_limit;

  // Next-state: load beats stepping; a limit step either wraps (and flags it) or holds.
  always_comb begin
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    wrap_d   = 1'b0;
    at_limit = S ? (cnt_q == CNT_MAX) : (cnt_q == CNT_ZERO);
    if (Load) begin
      cnt_d = D;
    end else if (I) begin
      dir_d = S;
      if (at_limit && (SATURATE != 0)) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d  = S ? (cnt_q + CNT_ONE) : (cnt_q - CNT_ONE);
        wrap_d = at_limit;
      end
    end
  end

  // State register with synchronous active-high reset; Dir resets to "up".
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q  <= CNT_ZERO;
      dir_q  <= 1'b1;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      wrap_q <= wrap_d;
    end
  end

  // Output encoding: Gray conversion is purely combinational on the registered count.
  generate
    if (GRAY != 0) begin : g_gray
      assign Q = cnt_q ^ (cnt_q >> 1);
    end else begin : g_bin
      assign Q = cnt_q;
    end
  endgenerate

  // Terminal state depends on the direction of the last accepted step.
  assign TC   = dir_q ? (cnt_q == CNT_MAX) : (cnt_q == CNT_ZERO);
  assign Dir  = dir_q;
  assign Wrap = wrap_q;

endmodule

// File: tb/tb_moore_seq_n.sv
// Directed bench for moore_seq_n: four parameterisations driven from shared inputs.
module tb_moore_seq_n;

  logic       Clock = 1'b0;
  logic       Reset, I, S, Load;
  logic [1:0] D2;
  logic [3:0] D4;

  logic [1:0] q_dflt, q_gray, q_sat;
  logic [3:0] q_w4;
  logic       dir_dflt, tc_dflt, wrap_dflt;
  logic       dir_gray, tc_gray, wrap_gray;
  logic       dir_sat, tc_sat, wrap_sat;
  logic       dir_w4, tc_w4, wrap_w4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clock = ~Clock;

  moore_seq_n #(.WIDTH(2), .GRAY(0), .SATURATE(0)) u_dflt (
    .Clock(Clock), .Reset(Reset), .I(I), .S(S), .Load(Load), .D(D2),
    .Q(q_dflt), .Dir(dir_dflt), .TC(tc_dflt), .Wrap(wrap_dflt));

  moore_seq_n #(.WIDTH(2), .GRAY(1), .SATURATE(0)) u_gray (
    .Clock(Clock), .Reset(Reset), .I(I), .S(S), .Load(Load), .D(D2),
    .Q(q_gray), .Dir(dir_gray), .TC(tc_gray), .Wrap(wrap_gray));

  moore_seq_n #(.WIDTH(2), .GRAY(0), .SATURATE(1)) u_sat (
    .Clock(Clock), .Reset(Reset), .I(I), .S(S), .Load(Load), .D(D2),
    .Q(q_sat), .Dir(dir_sat), .TC(tc_sat), .Wrap(wrap_sat));

  moore_seq_n #(.WIDTH(4), .GRAY(0), .SATURATE(0)) u_w4 (
    .Clock(Clock), .Reset(Reset), .I(I), .S(S), .Load(Load), .D(D4),
    .Q(q_w4), .Dir(dir_w4), .TC(tc_w4), .Wrap(wrap_w4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Expected per-cycle values for Reset then I=1 S=1 for six cycles.
  int exp_q_dflt [6] = '{1, 2, 3, 0, 1, 2};
  int exp_w_dflt [6] = '{0, 0, 0, 1, 0, 0};
  int exp_t_dflt [6] = '{0, 0, 1, 0, 0, 0};
  int exp_q_gray [6] = '{1, 3, 2, 0, 1, 3};
  int exp_q_sat  [6] = '{1, 2, 3, 3, 3, 3};
  int exp_t_sat  [6] = '{0, 0, 1, 1, 1, 1};

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; I = 1'b0; S = 1'b0; Load = 1'b0; D2 = 2'd0; D4 = 4'd0;
    step();
    chk("rst_q",    32'(q_dflt),    32'd0);
    chk("rst_dir",  32'(dir_dflt),  32'd1);
    chk("rst_tc",   32'(tc_dflt),   32'd0);
    chk("rst_wrap", 32'(wrap_dflt), 32'd0);
    chk("rst_qg",   32'(q_gray),    32'd0);

    // Count up across the wrap (binary / Gray / saturating)
    Reset = 1'b0; I = 1'b1; S = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("up_q",     32'(q_dflt),    32'(exp_q_dflt[k]));
      chk("up_wrap",  32'(wrap_dflt), 32'(exp_w_dflt[k]));
      chk("up_tc",    32'(tc_dflt),   32'(exp_t_dflt[k]));
      chk("gray_q",   32'(q_gray),    32'(exp_q_gray[k]));
      chk("gray_wr",  32'(wrap_gray), 32'(exp_w_dflt[k]));
      chk("gray_tc",  32'(tc_gray),   32'(exp_t_dflt[k]));
      chk("sat_q",    32'(q_sat),     32'(exp_q_sat[k]));
      chk("sat_wrap", 32'(wrap_sat),  32'd0);
      chk("sat_tc",   32'(tc_sat),    32'(exp_t_sat[k]));
    end

    // Down step from zero: wrap to max (or hold when saturating)
    Reset = 1'b1; I = 1'b0;
    step();
    Reset = 1'b0; I = 1'b1; S = 1'b0;
    step();
    chk("dn_q",      32'(q_dflt),    32'd3);
    chk("dn_dir",    32'(dir_dflt),  32'd0);
    chk("dn_wrap",   32'(wrap_dflt), 32'd1);
    chk("dn_tc",     32'(tc_dflt),   32'd0);
    chk("sdn_q",     32'(q_sat),     32'd0);
    chk("sdn_dir",   32'(dir_sat),   32'd0);
    chk("sdn_tc",    32'(tc_sat),    32'd1);
    chk("sdn_wrap",  32'(wrap_sat),  32'd0);
    chk("w4dn_q",    32'(q_w4),      32'd15);
    chk("w4dn_wrap", 32'(wrap_w4),   32'd1);
    I = 1'b0;
    step();
    chk("idle_wrap", 32'(wrap_dflt), 32'd0);
    chk("idle_q",    32'(q_dflt),    32'd3);

    // Load beats a simultaneous step; Dir kept
    Load = 1'b1; D2 = 2'd2; I = 1'b1; S = 1'b1;
    step();
    chk("ld_q",    32'(q_dflt),    32'd2);
    chk("ld_dir",  32'(dir_dflt),  32'd0);
    chk("ld_wrap", 32'(wrap_dflt), 32'd0);
    chk("ld_tc",   32'(tc_dflt),   32'd0);

    // Reset beats Load and I
    Reset = 1'b1;
    step();
    chk("rld_q",    32'(q_dflt),    32'd0);
    chk("rld_dir",  32'(dir_dflt),  32'd1);
    chk("rld_tc",   32'(tc_dflt),   32'd0);
    chk("rld_wrap", 32'(wrap_dflt), 32'd0);

    // Load of a limit value: TC with retained Dir, no Wrap
    Reset = 1'b0; Load = 1'b1; I = 1'b0; D2 = 2'd3;
    step();
    chk("ldl_q",    32'(q_dflt),    32'd3);
    chk("ldl_tc",   32'(tc_dflt),   32'd1);
    chk("ldl_wrap", 32'(wrap_dflt), 32'd0);

    // Reset on what would be a wrap step
    Load = 1'b0; Reset = 1'b1; I = 1'b1; S = 1'b1;
    step();
    chk("rwr_q",    32'(q_dflt),    32'd0);
    chk("rwr_wrap", 32'(wrap_dflt), 32'd0);
    chk("rwr_tc",   32'(tc_dflt),   32'd0);

    // WIDTH=4: load 15, wrap up to 0, then S toggles while idle
    Reset = 1'b0; I = 1'b0; Load = 1'b1; D4 = 4'd15; D2 = 2'd0;
    step();
    chk("w4ld_q",  32'(q_w4),  32'd15);
    chk("w4ld_tc", 32'(tc_w4), 32'd1);
    Load = 1'b0; I = 1'b1; S = 1'b1;
    step();
    chk("w4up_q",    32'(q_w4),    32'd0);
    chk("w4up_wrap", 32'(wrap_w4), 32'd1);
    chk("w4up_tc",   32'(tc_w4),   32'd0);
    I = 1'b0;
    for (int k = 0; k < 3; k++) begin
      S = ~S;
      step();
      chk("w4s_q",    32'(q_w4),    32'd0);
      chk("w4s_dir",  32'(dir_w4),  32'd1);
      chk("w4s_tc",   32'(tc_w4),   32'd0);
      chk("w4s_wrap", 32'(wrap_w4), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/moore_seq_n.md
MOORE_SEQ_N -- requirements
Module: moore_seq_n

Interface
REQ-001 Parameter WIDTH, default 2: state/output width in bits; legal range 1..16.
REQ-002 Parameter GRAY, default 0: 0 = Q is binary state; 1 = Q is Gray encoding of state.
REQ-003 Parameter SATURATE, default 0: 0 = count wraps at limits; 1 = count holds at limits.
REQ-004 Clock  input  1  sole clock; all state updates on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 I  input  1  advance request; one step per cycle while high.
REQ-007 S  input  1  step direction: 1 = up, 0 = down; sampled only when I=1.
REQ-008 Load  input  1  synchronous load of D into state.
REQ-009 D  input  WIDTH  load value (binary).
REQ-010 Q  output  WIDTH  Moore state output, encoded per GRAY.
REQ-011 Dir  output  1  registered direction of the last accepted step or reset value.
REQ-012 TC  output  1  terminal-state flag.
REQ-013 Wrap  output  1  one-cycle pulse marking a wrap-around step.

Function
REQ-014 Internal state cnt SHALL be a WIDTH-bit binary register; Q, TC SHALL be combinational functions of registered state only (Moore: no combinational path from I, S, Load, D to any output).
REQ-015 Q SHALL equal cnt when GRAY=0 and cnt ^ (cnt >> 1) when GRAY=1.
REQ-016 Per-cycle priority SHALL be Reset > Load > I > hold.
REQ-017 Load=1 (Reset=0): cnt <= D next edge; Dir unchanged; Wrap <= 0; I and S ignored that cycle.
REQ-018 I=1, Load=0, Reset=0: Dir <= S; cnt <= cnt+1 if S=1, cnt-1 if S=0, arithmetic modulo 2^WIDTH.
REQ-019 Limit step = I=1 with S=1 at cnt=2^WIDTH-1, or S=0 at cnt=0.
REQ-020 SATURATE=0, limit step: cnt wraps (max->0 or 0->max); Wrap <= 1 for exactly the following cycle.
REQ-021 SATURATE=1, limit step: cnt holds; Dir <= S; Wrap <= 0.
REQ-022 Wrap SHALL be 0 on every cycle not immediately following a wrapping step; consecutive wrapping steps (WIDTH=1 or continuous I) keep Wrap high for each.
REQ-023 I=0, Load=0, Reset=0: cnt and Dir hold; Wrap <= 0.
REQ-024 TC SHALL be 1 when (Dir=1 and cnt=2^WIDTH-1) or (Dir=0 and cnt=0), else 0.
REQ-025 Changing S while I=0 SHALL have no effect on any output or register.
REQ-026 Load of a limit value SHALL assert TC per REQ-024 with the retained Dir; it SHALL NOT assert Wrap.

Reset
REQ-027 Reset=1 at a rising edge: cnt <= 0, Dir <= 1, Wrap <= 0, hence Q = 0 and TC = 0 (WIDTH>=1) the following cycle.
REQ-028 Reset SHALL override Load and I in the same cycle, including mid-count and on a wrap step.
REQ-029 Outputs before the first Reset edge are undefined; the bench SHALL apply Reset for at least one edge.

Verification
REQ-030 Defaults, Reset 1 cycle, then I=1 S=1 for 5 cycles -> Q: 0,1,2,3,0,1; Wrap high only in the cycle Q=0 after 3; TC high only while Q=3.
REQ-031 GRAY=1, same stimulus -> Q: 00,01,11,10,00,01; Wrap/TC timing identical to REQ-030.
REQ-032 Defaults, from Q=0 apply I=1 S=0 one cycle -> Q=3, Dir=0, Wrap=1 next cycle; TC=0 (Dir=0, cnt!=0).
REQ-033 SATURATE=1, I=1 S=1 for 6 cycles from reset -> Q: 0,1,2,3,3,3,3; Wrap never 1; TC=1 from first Q=3 onward.
REQ-034 Load=1 D=2 together with I=1 S=1 -> Q=2 next cycle, Dir unchanged; then Reset=1 with Load=1 and I=1 -> Q=0, Dir=1, TC=0, Wrap=0.
REQ-035 WIDTH=4 SATURATE=0: Load D=15, then I=1 S=1 -> Q=0, Wrap=1; toggle S with I=0 for 3 cycles -> Q, Dir, TC unchanged.
